// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encoding, default sync marker and length-check helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

  // True when a frame announces more words than the memory can hold.
  function automatic logic len_too_big(input logic [15:0] n, input int aw);
    return {1'b0, n} > (17'd1 << aw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module : byte_packer
// Brief  : Assembles four LSB-first bytes into a 32-bit word; one-cycle strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q;
  logic [23:0] part_q;
  logic [31:0] word_q;
  logic        valid_q;

  assign last_o       = byte_valid_i && (idx_q == 2'd3);
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      part_q  <= 24'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= last_o;
      if (clr_i) begin
        idx_q  <= 2'd0;
        part_q <= 24'd0;
      end else if (byte_valid_i) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    part_q[7:0]   <= byte_i;
          2'd1:    part_q[15:8]  <= byte_i;
          2'd2:    part_q[23:16] <= byte_i;
          default: word_q        <= {byte_i, part_q};
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte-stream to imem word writer; holds the core until loaded.
//          Optional trailing checksum enabled by IMEM_LOADER_CKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE,
  parameter int         BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_q, state_d;
  logic              ready_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hold_q, done_q, err_q;

  logic              w_acc;
  logic [15:0]       w_len_n;
  logic              w_start, w_to_done, w_to_err, w_word_inc;
  logic              w_pk_valid, w_pk_last, w_pk_word_valid;
  logic [31:0]       w_pk_word;

  assign w_acc      = in_valid && ready_q;
  assign w_len_n    = {in_byte, len_lo_q};
  assign w_pk_valid = w_acc && (state_q == ST_DATA);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (w_start),
    .byte_valid_i (w_pk_valid),
    .byte_i       (in_byte),
    .last_o       (w_pk_last),
    .word_valid_o (w_pk_word_valid),
    .word_o       (w_pk_word)
  );

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'd0;
    end else if (w_start) begin
      sum_q <= 8'd0;
    end else if (w_pk_valid) begin
      sum_q <= sum_q + in_byte;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    w_start    = 1'b0;
    w_word_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_acc && (in_byte == SYNC_BYTE)) begin
          state_d = ST_LEN_LO;
          w_start = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (w_acc) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_acc) begin
          if (len_too_big(w_len_n, ADDR_W)) begin
            state_d = ST_ERR;
          end else if (w_len_n == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_pk_last) begin
          w_word_inc = 1'b1;
          if ((17'(words_q) + 17'd1) == {1'b0, len_q}) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (w_acc) state_d = (in_byte == sum_q) ? ST_DONE : ST_ERR;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    w_to_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    w_to_err  = (state_d == ST_ERR) && (state_q != ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      len_lo_q <= 8'd0;
      len_q    <= 16'd0;
      words_q  <= '0;
      addr_q   <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (w_acc && (state_q == ST_LEN_LO)) len_lo_q <= in_byte;
      if (w_acc && (state_q == ST_LEN_HI)) len_q <= w_len_n;
      if (w_start) begin
        hold_q  <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        words_q <= '0;
      end
      // Address is latched alongside the word so both appear with the strobe.
      if (w_word_inc) begin
        words_q <= words_q + 1'b1;
        addr_q  <= ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
      end
      if (w_to_done) begin
        hold_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (w_to_err) begin
        hold_q <= 1'b1;
        err_q  <= 1'b1;
      end
    end
  end

  assign in_ready     = ready_q;
  assign imem_wr_en   = w_pk_word_valid;
  assign imem_wr_addr = addr_q;
  assign imem_wr_data = w_pk_word;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed plus randomized frames against a frame-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb;
  logic [7:0]  ba, bb;
  logic        ra, rb, wea, web, holda, holdb, donea, doneb, erra, errb;
  logic [7:0]  waa;
  logic [1:0]  wab;
  logic [31:0] wda, wdb;
  logic [8:0]  wla;
  logic [2:0]  wlb;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_byte(ba),
    .imem_wr_en(wea), .imem_wr_addr(waa), .imem_wr_data(wda),
    .cpu_hold(holda), .load_done(donea), .load_error(erra), .words_loaded(wla)
  );

  imem_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5), .BASE_ADDR(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_byte(bb),
    .imem_wr_en(web), .imem_wr_addr(wab), .imem_wr_data(wdb),
    .cpu_hold(holdb), .load_done(doneb), .load_error(errb), .words_loaded(wlb)
  );

  always @(negedge clk) begin
    if (wea === 1'b1) begin qa0.push_back(32'(waa)); qd0.push_back(wda); end
    if (web === 1'b1) begin qa1.push_back(32'(wab)); qd1.push_back(wdb); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    if (d == 0) begin va = 1'b1; ba = b; end else begin vb = 1'b1; bb = b; end
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic status(input int d, input string tag, input logic hold, input logic done,
                        input logic err, input int words);
    if (d == 0) begin
      chk({tag, " hold"}, 32'(holda), 32'(hold));
      chk({tag, " done"}, 32'(donea), 32'(done));
      chk({tag, " err"}, 32'(erra), 32'(err));
      chk({tag, " words"}, 32'(wla), 32'(words));
    end else begin
      chk({tag, " hold"}, 32'(holdb), 32'(hold));
      chk({tag, " done"}, 32'(doneb), 32'(done));
      chk({tag, " err"}, 32'(errb), 32'(err));
      chk({tag, " words"}, 32'(wlb), 32'(words));
    end
  endtask

  task automatic clear_caps();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
  endtask

  // Reference: a frame of N words with N within capacity writes word i to
  // (BASE+i) mod capacity; an oversize N writes nothing and flags an error.
  task automatic run_frame(input int d, input int n, input bit corrupt, input string tag,
                           input logic [31:0] fixed0, input logic [31:0] fixed1, input bit use_fixed);
    int          aw   = (d == 0) ? 8 : 2;
    int          base = (d == 0) ? 0 : 2;
    int          cap  = 1 << aw;
    bit          ok   = (n <= cap);
    logic [7:0]  sum  = 8'd0;
    logic [31:0] w;
    logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
    bit          exp_done;
    repeat ($urandom_range(0, 2)) begin
      logic [7:0] junk = 8'($urandom);
      if (junk == 8'hA5) junk = 8'h00;
      send(d, junk);
    end
    clear_caps();
    send(d, 8'hA5);
    send(d, n[7:0]);
    send(d, n[15:8]);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = use_fixed ? ((i == 0) ? fixed0 : fixed1) : $urandom;
        for (int k = 0; k < 4; k++) begin
          send(d, w[8*k +: 8]);
          sum = sum + w[8*k +: 8];
        end
        exp_a.push_back(32'((base + i) % cap));
        exp_d.push_back(w);
      end
`ifdef IMEM_LOADER_CKSUM_EN
      send(d, corrupt ? sum + 8'd1 : sum);
`endif
    end
    repeat (2) @(negedge clk);
    exp_done = ok;
`ifdef IMEM_LOADER_CKSUM_EN
    exp_done = ok && !corrupt;
`endif
    got_a = (d == 0) ? qa0 : qa1;
    got_d = (d == 0) ? qd0 : qd1;
    chk({tag, " nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({tag, " addr"}, got_a[i], exp_a[i]);
      chk({tag, " data"}, got_d[i], exp_d[i]);
    end
    status(d, tag, !exp_done, exp_done, !exp_done, ok ? n : 0);
  endtask

  initial begin
    logic [7:0] pre[7];
    rst = 1'b1; va = 1'b0; vb = 1'b0; ba = 8'h00; bb = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(ra), 32'd0);
    chk("reset wr_en", 32'(wea), 32'd0);
    chk("reset addr", 32'(waa), 32'd0);
    chk("reset data", wda, 32'd0);
    status(0, "reset", 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle in_ready", 32'(ra), 32'd1);
    chk("idle no write", 32'(qa0.size() + qa1.size()), 32'd0);
    status(0, "idle", 1'b1, 1'b0, 1'b0, 0);

    run_frame(0, 2, 1'b0, "basic", 32'h00000013, 32'h0000006F, 1'b1);

    // A new sync after DONE re-holds the core before the new image lands.
    send(0, 8'hA5);
    status(0, "resync", 1'b1, 1'b0, 1'b0, 0);
    send(0, 8'h01);
    send(0, 8'h00);
    send(0, 8'h37); send(0, 8'h12); send(0, 8'h00); send(0, 8'h00);
`ifdef IMEM_LOADER_CKSUM_EN
    send(0, 8'h49);
`endif
    repeat (2) @(negedge clk);
    status(0, "reload", 1'b0, 1'b1, 1'b0, 1);
    chk("reload data", qd0[qd0.size()-1], 32'h00001237);

`ifdef IMEM_LOADER_CKSUM_EN
    run_frame(0, 2, 1'b1, "badck", 32'h00000013, 32'h0000006F, 1'b1);
    run_frame(0, 2, 1'b0, "goodck", 32'h00000013, 32'h0000006F, 1'b1);
`endif

    run_frame(1, 5, 1'b0, "oversize", 32'h0, 32'h0, 1'b0);
    run_frame(1, 0, 1'b0, "empty", 32'h0, 32'h0, 1'b0);
    run_frame(1, 4, 1'b0, "full_wrap", 32'h0, 32'h0, 1'b0);

    for (int it = 0; it < 14; it++) begin
      run_frame(it % 2, $urandom_range(0, 6), ($urandom_range(0, 3) == 0), "rand",
                32'h0, 32'h0, 1'b0);
    end

    // Reset in the middle of a payload aborts with no write issued.
    pre = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
    clear_caps();
    foreach (pre[i]) send(0, pre[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", 32'(ra), 32'd0);
    chk("midrst wr_en", 32'(wea), 32'd0);
    chk("midrst addr", 32'(waa), 32'd0);
    chk("midrst data", wda, 32'd0);
    status(0, "midrst", 1'b1, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst no write", 32'(qa0.size()), 32'd0);
    run_frame(0, 3, 1'b0, "post_rst", 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
